// File: rtl/puf_pkg.sv
// Shared types and helpers for the bistable-ring PUF evaluation sequencer.
package puf_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StRst,
        StSettle,
        StSample,
        StDone
    } state_e;

    localparam logic [1:0] LEN_32  = 2'b00;
    localparam logic [1:0] LEN_64  = 2'b01;
    localparam logic [1:0] LEN_128 = 2'b10;

    // Encodings 10 and 11 both select the full 128-stage ring.
    function automatic int unsigned len_to_bits(input logic [1:0] len);
        case (len)
            LEN_32:  return 32;
            LEN_64:  return 64;
            default: return 128;
        endcase
    endfunction

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchronizer for asynchronous single- or multi-bit level inputs.
module puf_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// PUF evaluation sequencer: loads the challenge serially, runs VOTES ring
// evaluations and majority-votes the sampled responses.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int unsigned CHAL_W        = 128,
    parameter int unsigned RESET_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned VOTES         = 7,
    parameter int unsigned CNT_W         = $clog2(VOTES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CHAL_W-1:0] chal,
    input  logic [1:0]        length_in,
    output logic              busy,
    output logic              done,
    output logic              resp,
    output logic [CNT_W-1:0]  ones_cnt,
    output logic              puf_si,
    output logic              puf_rstn,
    output logic              puf_reset,
    output logic [1:0]        puf_length,
    input  logic              puf_out
);

    localparam int unsigned MAX_RS = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES
                                                                    : SETTLE_CYCLES;
    localparam int unsigned MAX_PH = (CHAL_W > MAX_RS) ? CHAL_W : MAX_RS;
    localparam int unsigned PH_W   = $clog2(MAX_PH + 1);
    localparam int unsigned IDX_W  = $clog2(CHAL_W);

    state_e              state_q, state_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic [1:0]          len_q, len_d;
    logic [PH_W-1:0]     n_q, n_d;
    logic [PH_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]    vote_q, vote_d;
    logic [CNT_W-1:0]    ones_q, ones_d;
    logic                resp_q, resp_d;
    logic                rstn_q;
    logic                out_sync;
    logic [IDX_W-1:0]    shift_idx;

    puf_sync2 #(
        .WIDTH(1)
    ) u_out_sync (
        .clk  (clk),
        .reset(reset),
        .d    (puf_out),
        .q    (out_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            chal_q  <= '0;
            len_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            vote_q  <= '0;
            ones_q  <= '0;
            resp_q  <= 1'b0;
            rstn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chal_q  <= chal_d;
            len_q   <= len_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            vote_q  <= vote_d;
            ones_q  <= ones_d;
            resp_q  <= resp_d;
            rstn_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        chal_d  = chal_q;
        len_d   = len_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        vote_d  = vote_q;
        ones_d  = ones_q;
        resp_d  = resp_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    chal_d  = chal;
                    len_d   = length_in;
                    n_d     = PH_W'(len_to_bits(length_in));
                    cnt_d   = '0;
                    vote_d  = '0;
                    ones_d  = '0;
                    resp_d  = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                cnt_d = cnt_q + PH_W'(1);
                if (cnt_q == n_q - PH_W'(1)) begin
                    cnt_d   = '0;
                    state_d = StRst;
                end
            end
            StRst: begin
                cnt_d = cnt_q + PH_W'(1);
                if (cnt_q == PH_W'(RESET_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + PH_W'(1);
                if (cnt_q == PH_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StSample;
                end
            end
            StSample: begin
                ones_d = ones_q + CNT_W'(out_sync);
                vote_d = vote_q + CNT_W'(1);
                // The challenge stays loaded, so further votes restart at the ring reset.
                if (vote_d == CNT_W'(VOTES)) begin
                    resp_d  = (ones_d > CNT_W'(VOTES / 2));
                    state_d = StDone;
                end else begin
                    state_d = StRst;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // MSB of the active slice goes out first.
    assign shift_idx = IDX_W'(n_q - PH_W'(1) - cnt_q);

    always_comb begin
        busy       = !reset && (state_q != StIdle);
        done       = !reset && (state_q == StDone);
        resp       = !reset && resp_q;
        ones_cnt   = reset ? '0 : ones_q;
        puf_si     = !reset && (state_q == StShift) && chal_q[shift_idx];
        puf_rstn   = !reset && rstn_q;
        puf_reset  = reset || !((state_q == StSettle) || (state_q == StSample));
        puf_length = reset ? 2'b00 : len_q;
    end

endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
- Sequencer directly upstream and downstream of the bistable-ring PUF top (puf_super).
- Per evaluation it:
  - serially loads a parallel challenge into the PUF challenge shift register;
  - runs VOTES ring evaluations, each a reset pulse, a settle wait and one sample of the PUF output;
  - returns a majority-voted response bit plus the ones count as a stability metric.
- Drives si, rstn, reset and length of puf_super and consumes its out.

Parameters:
- CHAL_W, 128, challenge width; equals the widest ring.
- RESET_CYCLES, 4, cycles puf_reset is held high per evaluation; ≥1.
- SETTLE_CYCLES, 64, cycles after puf_reset release before sampling; ≥2 to cover the synchronizer.
- VOTES, 7, evaluations per response; odd, ≥1.
- CNT_W, $clog2(VOTES+1), width of ones_cnt.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request an evaluation; sampled only in IDLE.
- chal, input, CHAL_W, challenge; captured on start acceptance.
- length_in, input, 2, ring select: 00=32, 01=64, 10/11=128; captured on start.
- busy, output, 1, high from the cycle after acceptance through DONE.
- done, output, 1, one-cycle pulse; resp and ones_cnt valid.
- resp, output, 1, majority-voted response bit.
- ones_cnt, output, CNT_W, number of samples equal to 1.
- puf_si, output, 1, to puf_super si.
- puf_rstn, output, 1, to puf_super rstn (challenge register clear, active low).
- puf_reset, output, 1, to puf_super reset; high holds the ring.
- puf_length, output, 2, to puf_super length.
- puf_out, input, 1, from puf_super out; asynchronous to clk.

Behaviour:
- Reset values (also during reset):
  - state=IDLE; busy=0, done=0, resp=0, ones_cnt=0.
  - puf_si=0, puf_rstn=0, puf_reset=1, puf_length=00.
  - Synchronizer flops = 0.
  - puf_rstn returns to 1 the first cycle after reset deasserts.
- puf_out passes through a 2-flop synchronizer; only the synced value is sampled.
- N (shift count) = 32/64/128 for length_in 00/01/(10 or 11), latched at acceptance. puf_length = latched length_in.
- IDLE:
  - puf_reset=1.
  - start=1 → capture chal and length, clear ones_cnt and vote counter, go SHIFT next cycle.
- SHIFT, N cycles:
  - puf_si = chal_q[N-1-k] on shift cycle k, MSB of the active slice first.
  - After N clk edges, the challenge register holds chal_q[N-1:0] in c[N-1:0]. Higher c bits are don't-care.
  - puf_reset stays 1.
- RST, RESET_CYCLES cycles: puf_reset=1.
- SETTLE, SETTLE_CYCLES cycles: puf_reset=0.
- SAMPLE, 1 cycle:
  - puf_reset=0.
  - ones_cnt += synced out; votes += 1.
  - If votes==VOTES go DONE, else go RST. No re-shift; the challenge stays loaded.
- DONE, 1 cycle:
  - done=1, puf_reset=1.
  - resp = (ones_cnt > VOTES/2).
  - Next state IDLE.
- Output holding:
  - resp and ones_cnt hold until the next acceptance.
  - ones_cnt visibly accumulates while busy; it is only valid at done.
- start while busy or in DONE is ignored, not queued. start in the same cycle done pulses is ignored.
- Latency: accept → done = 1 + N + VOTES·(RESET_CYCLES+SETTLE_CYCLES+1) cycles.
  - Default, N=32: 1+32+7·69 = 516.
- All counters are sized for their maximum values and never wrap within a phase.
- Reset mid-operation → IDLE on the next edge. No done pulse; resp is cleared.

Decomposition:
- Shared package puf_pkg holds:
  - the state enum (IDLE, SHIFT, RST, SETTLE, SAMPLE, DONE);
  - length encodings LEN_32/LEN_64/LEN_128;
  - a function len_to_bits().
- One sub-module: puf_sync2, the 2-flop synchronizer for puf_out, reusable for other async inputs.

Test Plan:
- Shift order:
  - Stimulus: length_in=00, chal=32'hA5000001, start.
  - Required: puf_si over the 32 shift cycles = 1,0,1,0,0,1,0,1, then 23×0, then 1. puf_reset=1 throughout SHIFT.
- All-ones ring:
  - Stimulus: puf_out tied 1, VOTES=7.
  - Required: done at cycle 516 after acceptance; resp=1, ones_cnt=7.
  - Required: exactly 7 puf_reset high→low transitions, each followed by 64 low cycles (SETTLE) plus 1 low SAMPLE cycle.
- Marginal vote:
  - Stimulus: model drives puf_out=1 on evaluations 1–3 and 0 on 4–7.
  - Required: resp=0, ones_cnt=3. Then 4 ones of 7 → resp=1, ones_cnt=4.
- Length 11:
  - Stimulus: length_in=11.
  - Required: 128 shift cycles; puf_length=11; done at 1+128+483=612.
- Busy protection:
  - Stimulus: start pulsed at cycles 5 and 300 after the first acceptance.
  - Required: exactly one done; chal changes after acceptance do not alter puf_si.
- Reset mid-SETTLE:
  - Stimulus: reset for 1 cycle during SETTLE.
  - Required: next cycle busy=0, puf_reset=1, puf_rstn=0, resp=0, no done. A new start then completes normally.
